// File: rtl/tank_combat_if.sv
// tank_combat_if: pixel-event inputs and combat-result outputs of the tank combat manager.
interface tank_combat_if #(parameter int NUM_TANKS = 4);
  logic                   frame_start_i;
  logic                   display_enable_i;
  logic [NUM_TANKS-1:0]   tank_box_i;
  logic [NUM_TANKS-1:0]   bullet_i;
  logic                   all_hard_block_i;
  logic                   destroyable_block_i;
  logic                   eagle_block_i;
  logic [NUM_TANKS-1:0]   bullet_explode_o;
  logic [NUM_TANKS-1:0]   die_o;
  logic [NUM_TANKS-1:0]   revive_o;
  logic [NUM_TANKS-1:0]   alive_o;
  logic [NUM_TANKS*4-1:0] lives_o;
  logic                   bullet_collide_wall_o;
  logic                   bullet_collide_eagle_o;
  logic                   eagle_destroyed_o;
  logic                   game_over_o;
  modport master (
    output frame_start_i, display_enable_i, tank_box_i, bullet_i,
           all_hard_block_i, destroyable_block_i, eagle_block_i,
    input  bullet_explode_o, die_o, revive_o, alive_o, lives_o,
           bullet_collide_wall_o, bullet_collide_eagle_o, eagle_destroyed_o, game_over_o
  );
  modport slave (
    input  frame_start_i, display_enable_i, tank_box_i, bullet_i,
           all_hard_block_i, destroyable_block_i, eagle_block_i,
    output bullet_explode_o, die_o, revive_o, alive_o, lives_o,
           bullet_collide_wall_o, bullet_collide_eagle_o, eagle_destroyed_o, game_over_o
  );
endinterface

// File: rtl/tank_combat_manager.sv
// tank_combat_manager: per-pixel bullet/tank/map collision resolution with per-tank life FSMs.
module tank_combat_manager #(
  parameter int                     NUM_TANKS      = 4,
  parameter logic [NUM_TANKS*4-1:0] LIVES_INIT     = {4'd1, 4'd1, 4'd3, 4'd3},
  parameter logic [7:0]             RESPAWN_FRAMES = 8'd60,
  parameter logic [NUM_TANKS-1:0]   TEAM_MASK      = 4'b0011,
  parameter logic                   FRIENDLY_FIRE  = 1'b0
) (
  input logic         clk_i,
  input logic         reset_ni,
  tank_combat_if.slave bus
);
  typedef enum logic [1:0] {ALIVE, DEAD, OUT} state_t;
  state_t                 st [NUM_TANKS];
  state_t                 st_n [NUM_TANKS];
  logic [7:0]             cnt [NUM_TANKS];
  logic [7:0]             cnt_n [NUM_TANKS];
  logic [NUM_TANKS*4-1:0] lives, lives_n;
  logic [NUM_TANKS-1:0]   alive, alive_n, box_m, bul_m, tank_hit, bul_hit;
  logic [NUM_TANKS-1:0]   expl_c, expl, expl_n, sup, sup_eff, sup_n, die, die_n, rev, rev_n;
  logic                   wall, wall_n, ecol, ecol_n, ed, ed_n, go, go_n, eag_hit, po;
  logic [3:0]             lv;
  always_comb begin
    box_m    = bus.tank_box_i & alive & {NUM_TANKS{bus.display_enable_i}};
    bul_m    = bus.bullet_i & alive & {NUM_TANKS{bus.display_enable_i}};
    tank_hit = '0;
    bul_hit  = '0;
    eag_hit  = 1'b0;
    for (int i = 0; i < NUM_TANKS; i++) begin
      for (int j = 0; j < NUM_TANKS; j++)
        if (i != j && (FRIENDLY_FIRE || TEAM_MASK[i] != TEAM_MASK[j]) && bul_m[i] && box_m[j]) begin
          tank_hit[j] = 1'b1;
          bul_hit[i]  = 1'b1;
        end
      if (bul_m[i] && bus.eagle_block_i && (FRIENDLY_FIRE || !TEAM_MASK[i])) eag_hit = 1'b1;
    end
    expl_c  = bul_m & (bul_hit | {NUM_TANKS{bus.all_hard_block_i | bus.destroyable_block_i | bus.eagle_block_i}});
    // a frame start clears suppression before the same-cycle event is judged
    sup_eff = bus.frame_start_i ? '0 : sup;
    expl_n  = expl_c & ~sup_eff;
    sup_n   = sup_eff | expl_c;
    wall_n  = |bul_m & bus.destroyable_block_i;
    ecol_n  = |bul_m & bus.eagle_block_i;
    lives_n = lives;
    die_n   = '0;
    rev_n   = '0;
    lv      = 4'd0;
    for (int k = 0; k < NUM_TANKS; k++) begin
      st_n[k]  = st[k];
      cnt_n[k] = cnt[k];
      lv       = lives[4*k +: 4];
      if (!go) begin
        if (st[k] == ALIVE && tank_hit[k]) begin
          st_n[k]           = DEAD;
          die_n[k]          = 1'b1;
          lives_n[4*k +: 4] = lv == 4'd0 ? 4'd0 : lv - 4'd1;
          cnt_n[k]          = RESPAWN_FRAMES;
        end else if (st[k] == DEAD && bus.frame_start_i) begin
          cnt_n[k] = cnt[k] == 8'd0 ? 8'd0 : cnt[k] - 8'd1;
          if (cnt[k] <= 8'd1) begin
            st_n[k]  = lv != 4'd0 ? ALIVE : OUT;
            rev_n[k] = lv != 4'd0;
          end
        end
      end
    end
    po = |TEAM_MASK;
    for (int k = 0; k < NUM_TANKS; k++) begin
      alive_n[k] = st_n[k] == ALIVE;
      if (TEAM_MASK[k] && st_n[k] != OUT) po = 1'b0;
    end
    ed_n = ed | eag_hit;
    go_n = go | ed_n | po;
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int k = 0; k < NUM_TANKS; k++) begin
        st[k]    <= LIVES_INIT[4*k +: 4] != 4'd0 ? ALIVE : OUT;
        cnt[k]   <= 8'd0;
        alive[k] <= LIVES_INIT[4*k +: 4] != 4'd0;
      end
      lives <= LIVES_INIT;
      sup   <= '0;
      expl  <= '0;
      die   <= '0;
      rev   <= '0;
      wall  <= 1'b0;
      ecol  <= 1'b0;
      ed    <= 1'b0;
      go    <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_TANKS; k++) begin
        st[k]  <= st_n[k];
        cnt[k] <= cnt_n[k];
      end
      alive <= alive_n;
      lives <= lives_n;
      sup   <= sup_n;
      expl  <= expl_n;
      die   <= die_n;
      rev   <= rev_n;
      wall  <= wall_n;
      ecol  <= ecol_n;
      ed    <= ed_n;
      go    <= go_n;
    end
  end
  assign bus.bullet_explode_o       = expl;
  assign bus.die_o                  = die;
  assign bus.revive_o               = rev;
  assign bus.alive_o                = alive;
  assign bus.lives_o                = lives;
  assign bus.bullet_collide_wall_o  = wall;
  assign bus.bullet_collide_eagle_o = ecol;
  assign bus.eagle_destroyed_o      = ed;
  assign bus.game_over_o            = go;
endmodule

// File: tb/tb_tank_combat_manager.sv
// tb_tank_combat_manager: scoreboard bench for tank_combat_manager with RESPAWN_FRAMES=2.
module tb_tank_combat_manager;
  typedef struct packed {
    logic [3:0]  x, d, r, al;
    logic [15:0] lv;
    logic        w, ec, ed, go;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset_ni = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;
  exp_t       sb [$];
  logic [3:0] e_alive, pa;
  logic [15:0] e_lives;
  logic       e_ed, e_go;
  tank_combat_if #(.NUM_TANKS(4)) bus ();
  tank_combat_manager #(.RESPAWN_FRAMES(8'd2)) dut (.clk_i(clk), .reset_ni(reset_ni), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic fs, input logic de, input logic [3:0] box, input logic [3:0] bul, input logic [2:0] blk);
    bus.frame_start_i       = fs;
    bus.display_enable_i    = de;
    bus.tank_box_i          = box;
    bus.bullet_i            = bul;
    bus.all_hard_block_i    = blk[2];
    bus.destroyable_block_i = blk[1];
    bus.eagle_block_i       = blk[0];
  endtask
  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".explode"}, 32'(bus.bullet_explode_o), 32'(e.x));
    check({tag, ".die"}, 32'(bus.die_o), 32'(e.d));
    check({tag, ".revive"}, 32'(bus.revive_o), 32'(e.r));
    check({tag, ".alive"}, 32'(bus.alive_o), 32'(e.al));
    check({tag, ".lives"}, 32'(bus.lives_o), 32'(e.lv));
    check({tag, ".wall"}, 32'(bus.bullet_collide_wall_o), 32'(e.w));
    check({tag, ".eagle_col"}, 32'(bus.bullet_collide_eagle_o), 32'(e.ec));
    check({tag, ".eagle_dst"}, 32'(bus.eagle_destroyed_o), 32'(e.ed));
    check({tag, ".game_over"}, 32'(bus.game_over_o), 32'(e.go));
  endtask
  task automatic step(input string tag, input logic fs, input logic de, input logic [3:0] box, input logic [3:0] bul,
                      input logic [2:0] blk, input logic [3:0] x, input logic [3:0] d, input logic [3:0] r);
    exp_t e;
    drive(fs, de, box, bul, blk);
    e = '{x: x, d: d, r: r, al: e_alive, lv: e_lives,
          w: de & blk[1] & (|(bul & pa)), ec: de & blk[0] & (|(bul & pa)), ed: e_ed, go: e_go};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) check({tag, ".sb_empty"}, 32'd1, 32'd0);
    else check_all(tag, sb.pop_front());
    pa = e_alive;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 3'b000);
  endtask
  task automatic do_reset();
    drive(1'b0, 1'b0, 4'h0, 4'h0, 3'b000);
    reset_ni = 1'b0;
    e_lives  = 16'h1133;
    e_alive  = 4'hF;
    e_ed     = 1'b0;
    e_go     = 1'b0;
    pa       = 4'hF;
    #13;
    check_all("reset", '{x: 4'h0, d: 4'h0, r: 4'h0, al: 4'hF, lv: 16'h1133, w: 1'b0, ec: 1'b0, ed: 1'b0, go: 1'b0});
    @(negedge clk);
    reset_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    do_reset();
    step("no_de", 1'b0, 1'b0, 4'h1, 4'h4, 3'b000, 4'h0, 4'h0, 4'h0);
    e_lives = 16'h1132; e_alive = 4'hE;
    step("hit0", 1'b0, 1'b1, 4'h1, 4'h4, 3'b000, 4'h4, 4'h1, 4'h0);
    step("dead_mask", 1'b0, 1'b1, 4'h1, 4'h4, 3'b000, 4'h0, 4'h0, 4'h0);
    step("frame1", 1'b1, 1'b0, 4'h0, 4'h0, 3'b000, 4'h0, 4'h0, 4'h0);
    e_alive = 4'hF;
    step("revive0", 1'b1, 1'b0, 4'h0, 4'h0, 3'b000, 4'h0, 4'h0, 4'h1);
    step("same_team", 1'b0, 1'b1, 4'h2, 4'h1, 3'b000, 4'h0, 4'h0, 4'h0);
    step("hard1", 1'b0, 1'b1, 4'h0, 4'h1, 3'b100, 4'h1, 4'h0, 4'h0);
    step("hard_sup", 1'b0, 1'b1, 4'h0, 4'h1, 3'b100, 4'h0, 4'h0, 4'h0);
    step("fs_clear", 1'b1, 1'b1, 4'h0, 4'h1, 3'b100, 4'h1, 4'h0, 4'h0);
    e_lives = 16'h1122; e_alive = 4'hD;
    step("double_hit", 1'b0, 1'b1, 4'h2, 4'hC, 3'b000, 4'hC, 4'h2, 4'h0);
    step("rehit_frame", 1'b0, 1'b1, 4'h2, 4'hC, 3'b000, 4'h0, 4'h0, 4'h0);
    step("frame1b", 1'b1, 1'b0, 4'h0, 4'h0, 3'b000, 4'h0, 4'h0, 4'h0);
    e_alive = 4'hF;
    step("revive1", 1'b1, 1'b0, 4'h0, 4'h0, 3'b000, 4'h0, 4'h0, 4'h2);
    step("wall1", 1'b0, 1'b1, 4'h0, 4'h2, 3'b010, 4'h2, 4'h0, 4'h0);
    step("wall2", 1'b0, 1'b1, 4'h0, 4'h2, 3'b010, 4'h0, 4'h0, 4'h0);
    e_lives = 16'h1022; e_alive = 4'hB;
    step("hit2", 1'b0, 1'b1, 4'h4, 4'h1, 3'b000, 4'h1, 4'h4, 4'h0);
    step("frame1c", 1'b1, 1'b0, 4'h0, 4'h0, 3'b000, 4'h0, 4'h0, 4'h0);
    step("no_revive2", 1'b1, 1'b0, 4'h0, 4'h0, 3'b000, 4'h0, 4'h0, 4'h0);
    step("out2", 1'b1, 1'b0, 4'h0, 4'h0, 3'b000, 4'h0, 4'h0, 4'h0);
    step("player_eagle", 1'b0, 1'b1, 4'h0, 4'h1, 3'b001, 4'h1, 4'h0, 4'h0);
    e_ed = 1'b1; e_go = 1'b1;
    step("enemy_eagle", 1'b0, 1'b1, 4'h0, 4'h8, 3'b001, 4'h8, 4'h0, 4'h0);
    step("frozen", 1'b1, 1'b1, 4'h1, 4'h8, 3'b000, 4'h8, 4'h0, 4'h0);
    do_reset();
    e_lives = 16'h1132; e_alive = 4'hE;
    step("hit0_r", 1'b0, 1'b1, 4'h1, 4'h4, 3'b000, 4'h4, 4'h1, 4'h0);
    step("frame_r", 1'b1, 1'b0, 4'h0, 4'h0, 3'b000, 4'h0, 4'h0, 4'h0);
    #2;
    reset_ni = 1'b0;
    #1;
    check("async_lives", 32'(bus.lives_o), 32'h1133);
    check("async_alive", 32'(bus.alive_o), 32'hF);
    do_reset();
    step("post_rst_f1", 1'b1, 1'b0, 4'h0, 4'h0, 3'b000, 4'h0, 4'h0, 4'h0);
    step("post_rst_f2", 1'b1, 1'b0, 4'h0, 4'h0, 3'b000, 4'h0, 4'h0, 4'h0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
